// File: rtl/memory_card_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_card_if
//  Description : Control-bus memory handshake bundle. The control card is the
//                master (drives address, write data and the two requests);
//                the memory card is the slave (drives read data, bus enable,
//                acknowledges and the write-protect error pulse).
//  Revision    : 1.0  initial release
// ============================================================================
interface memory_card_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] address;
    logic [DATAWIDTH-1:0] data_in;
    logic [DATAWIDTH-1:0] data_out;
    logic                 data_oe;
    logic                 rd_req;
    logic                 wr_req;
    logic                 rd_ready;
    logic                 wr_done;
    logic                 wp_err;

    modport master (
        output address,
        output data_in,
        output rd_req,
        output wr_req,
        input  data_out,
        input  data_oe,
        input  rd_ready,
        input  wr_done,
        input  wp_err
    );

    modport slave (
        input  address,
        input  data_in,
        input  rd_req,
        input  wr_req,
        output data_out,
        output data_oe,
        output rd_ready,
        output wr_done,
        output wp_err
    );
endinterface
`default_nettype wire

// File: rtl/memory_card.sv
`default_nettype none
// ============================================================================
//  Module      : memory_card
//  Description : Responder end of the control-bus memory handshake. A
//                single-port synchronous RAM served through a 4-phase
//                rd_req/rd_ready and wr_req/wr_done handshake with a fixed
//                number of programmable wait states. All outputs are
//                registered on posedge so they are stable for a control card
//                sampling on negedge.
//  Options     : define MEMCARD_WPROT_EN to make addresses below ROM_TOP
//                read-only (writes are acknowledged but dropped, wp_err
//                pulses for one cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module memory_card #(
    parameter int          DATAWIDTH   = 8,
    parameter int          ADDRWIDTH   = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter int unsigned ROM_TOP     = 32'h10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    memory_card_if.slave   bus
);

    localparam int         c_DEPTH     = 2 ** ADDRWIDTH;
    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_ACK  = 3'd2,
        WR_WAIT = 3'd3,
        WR_ACK  = 3'd4
    } state_t;

    state_t                 state_q,    state_d;
    logic [3:0]             cnt_q,      cnt_d;
    logic [DATAWIDTH-1:0]   addr_q,     addr_d;
    logic [DATAWIDTH-1:0]   wdata_q,    wdata_d;
    logic [DATAWIDTH-1:0]   dout_q,     dout_d;
    logic                   rd_ready_q, rd_ready_d;
    logic                   wr_done_q,  wr_done_d;
    logic                   oe_q,       oe_d;
    logic                   wp_err_q,   wp_err_d;

    logic [DATAWIDTH-1:0]   mem [c_DEPTH];
    logic [ADDRWIDTH-1:0]   w_index;
    logic [DATAWIDTH-1:0]   w_rd_word;
    logic                   w_mem_we;
    logic                   w_prot;

    // Upper address bits are dropped, so addresses alias modulo the depth.
    assign w_index   = addr_q[ADDRWIDTH-1:0];
    assign w_rd_word = mem[w_index];

`ifdef MEMCARD_WPROT_EN
    localparam logic [DATAWIDTH-1:0] c_ROM_TOP = DATAWIDTH'(ROM_TOP);

    // Protection is judged on the full latched bus address, not the RAM index.
    assign w_prot     = (addr_q < c_ROM_TOP);
    assign bus.wp_err = wp_err_q;
`else
    logic w_unused_cfg;

    assign w_prot       = 1'b0;
    assign bus.wp_err   = 1'b0;
    assign w_unused_cfg = ^{addr_q, wp_err_q, (ROM_TOP != 32'd0)};
`endif

    assign bus.data_out = dout_q;
    assign bus.data_oe  = oe_q;
    assign bus.rd_ready = rd_ready_q;
    assign bus.wr_done  = wr_done_q;

    // Handshake state and all registered outputs; RAM is deliberately not here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
            rd_ready_q <= 1'b0;
            wr_done_q  <= 1'b0;
            oe_q       <= 1'b0;
            wp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            rd_ready_q <= rd_ready_d;
            wr_done_q  <= wr_done_d;
            oe_q       <= oe_d;
            wp_err_q   <= wp_err_d;
        end
    end

    // Next-state logic: accept in IDLE, count wait states, acknowledge, release.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        rd_ready_d = rd_ready_q;
        wr_done_d  = wr_done_q;
        oe_d       = oe_q;
        wp_err_d   = 1'b0;
        w_mem_we   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write has priority when both requests are raised together.
                if (bus.wr_req) begin
                    state_d = WR_WAIT;
                    addr_d  = bus.address;
                    wdata_d = bus.data_in;
                    cnt_d   = 4'd0;
                end else if (bus.rd_req) begin
                    state_d = RD_WAIT;
                    addr_d  = bus.address;
                    cnt_d   = 4'd0;
                end
            end

            RD_WAIT: begin
                // A withdrawn request abandons the transfer without an ack.
                if (!bus.rd_req) begin
                    state_d = IDLE;
                end else if (cnt_q == c_WAIT_LAST) begin
                    dout_d     = w_rd_word;
                    rd_ready_d = 1'b1;
                    oe_d       = 1'b1;
                    state_d    = RD_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            WR_WAIT: begin
                if (!bus.wr_req) begin
                    state_d = IDLE;
                end else if (cnt_q == c_WAIT_LAST) begin
                    // Protected writes still complete the handshake.
                    wr_done_d = 1'b1;
                    state_d   = WR_ACK;
                    if (w_prot) begin
                        wp_err_d = 1'b1;
                    end else begin
                        w_mem_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            RD_ACK: begin
                if (!bus.rd_req) begin
                    dout_d     = '0;
                    rd_ready_d = 1'b0;
                    oe_d       = 1'b0;
                    state_d    = IDLE;
                end
            end

            WR_ACK: begin
                if (!bus.wr_req) begin
                    wr_done_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM write port; the enable comes from the reset state register, so a
    // reset during WR_WAIT can never leave a partial write behind.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_index] <= wdata_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_card.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_card
//  Description : Bench for memory_card. Two instances: the default build
//                (8-bit index, 2 wait states) and a 4-bit index / 0 wait state
//                build for address aliasing. The bench drives one shared set
//                of control-card signals, steered to one instance by sel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_card;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_BOTH = 2;
    localparam int OP_RDAB = 3;
    localparam int OP_WRAB = 4;

    typedef struct {
        int         op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       rd_req  = 1'b0;
    logic       wr_req  = 1'b0;

    logic [7:0] data_out;
    logic       data_oe, rd_ready, wr_done, wp_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory contents, one image per instance, with known flags.
    logic [7:0] m0 [256];
    bit         v0 [256];
    logic [7:0] m1 [16];
    bit         v1 [16];

    memory_card_if #(.DATAWIDTH(8)) bus0 ();
    memory_card_if #(.DATAWIDTH(8)) bus1 ();

    assign bus0.address = address;
    assign bus0.data_in = data_in;
    assign bus0.rd_req  = rd_req & ~sel;
    assign bus0.wr_req  = wr_req & ~sel;
    assign bus1.address = address;
    assign bus1.data_in = data_in;
    assign bus1.rd_req  = rd_req & sel;
    assign bus1.wr_req  = wr_req & sel;

    assign data_out = sel ? bus1.data_out : bus0.data_out;
    assign data_oe  = sel ? bus1.data_oe  : bus0.data_oe;
    assign rd_ready = sel ? bus1.rd_ready : bus0.rd_ready;
    assign wr_done  = sel ? bus1.wr_done  : bus0.wr_done;
    assign wp_err   = sel ? bus1.wp_err   : bus0.wp_err;

    memory_card #(.DATAWIDTH(8), .ADDRWIDTH(8), .WAIT_CYCLES(2), .ROM_TOP(32'h10)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    memory_card #(.DATAWIDTH(8), .ADDRWIDTH(4), .WAIT_CYCLES(0), .ROM_TOP(32'h10)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    function automatic bit prot(input logic [7:0] a);
`ifdef MEMCARD_WPROT_EN
        return a < 8'h10;
`else
        return (a == 8'h00) && 1'b0;
`endif
    endfunction

    // One complete transaction from the control card's point of view.
    // Called and returns on a negedge with both requests low.
    task automatic txn(input int op, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rdata);
        int   w, lat, wpc;
        bit   is_wr, abort, quiet, wp_at_ack, known, ack;
        logic [7:0] expd, held;
        w     = sel ? 0 : 2;
        is_wr = (op == OP_WR) || (op == OP_BOTH) || (op == OP_WRAB);
        abort = (op == OP_RDAB) || (op == OP_WRAB);
        rdata = 8'h00;
        address = a;
        data_in = d;
        wr_req  = is_wr;
        rd_req  = (op == OP_RD) || (op == OP_BOTH) || (op == OP_RDAB);

        if (abort) begin
            quiet = 1'b1;
            @(negedge clk);
            if (rd_ready || wr_done || data_oe || wp_err) quiet = 1'b0;
            wr_req  = 1'b0;
            rd_req  = 1'b0;
            address = 8'($urandom);
            repeat (w + 3) begin
                @(negedge clk);
                if (rd_ready || wr_done || data_oe || wp_err) quiet = 1'b0;
            end
            chk("abort_no_ack", 32'(quiet), 32'd1);
            return;
        end

        lat = 0;
        wpc = 0;
        wp_at_ack = 1'b0;
        for (int k = 1; k <= w + 6; k++) begin
            @(negedge clk);
            if (wp_err) wpc++;
            ack = is_wr ? wr_done : rd_ready;
            if (ack) begin
                lat = k;
                wp_at_ack = wp_err;
                break;
            end
            chk("oe_during_wait", 32'(data_oe), 32'd0);
            chk("other_ack_low", 32'(is_wr ? rd_ready : wr_done), 32'd0);
            // Bus changes after acceptance must be ignored.
            address = 8'($urandom);
            data_in = 8'($urandom);
        end
        chk("ack_latency", 32'(lat), 32'(w + 2));

        if (lat != 0) begin
            if (is_wr) begin
                chk("wr_oe_low", 32'(data_oe), 32'd0);
                chk("wr_rd_ready_low", 32'(rd_ready), 32'd0);
                chk("wp_err_at_ack", 32'(wp_at_ack), 32'(prot(a)));
                if (!prot(a)) begin
                    if (sel) begin m1[a[3:0]] = d; v1[a[3:0]] = 1'b1; end
                    else     begin m0[a] = d;      v0[a] = 1'b1; end
                end
            end else begin
                chk("rd_oe_high", 32'(data_oe), 32'd1);
                known = sel ? v1[a[3:0]] : v0[a];
                expd  = sel ? m1[a[3:0]] : m0[a];
                if (known) begin
                    chk("rd_data", 32'(data_out), 32'(expd));
                end else begin
                    // Unwritten RAM holds an arbitrary value that must then stay put.
                    if (sel) begin m1[a[3:0]] = data_out; v1[a[3:0]] = 1'b1; end
                    else     begin m0[a] = data_out;      v0[a] = 1'b1; end
                end
                rdata = data_out;
            end
            held = data_out;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                if (wp_err) wpc++;
                chk("ack_hold", 32'(is_wr ? wr_done : rd_ready), 32'd1);
                if (!is_wr) chk("rd_data_hold", 32'(data_out), 32'(held));
            end
        end

        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        if (wp_err) wpc++;
        chk("ack_clear", 32'({rd_ready, wr_done, data_oe}), 32'd0);
        chk("dout_clear", 32'(data_out), 32'd0);
        chk("wp_err_count", 32'(wpc), 32'((is_wr && prot(a)) ? 1 : 0));
    endtask

    initial begin
        vec_t       tbl [12];
        logic [7:0] rd;
        logic [7:0] snap;
        int         op;
        logic [7:0] a;

        tbl[0]  = '{OP_WR,   8'h20, 8'h5A, 8'h00};
        tbl[1]  = '{OP_RD,   8'h20, 8'h00, 8'h5A};
        tbl[2]  = '{OP_WR,   8'h21, 8'h11, 8'h00};
        tbl[3]  = '{OP_WRAB, 8'h21, 8'hEE, 8'h00};
        tbl[4]  = '{OP_RD,   8'h21, 8'h00, 8'h11};
        tbl[5]  = '{OP_RDAB, 8'h20, 8'h00, 8'h00};
        tbl[6]  = '{OP_BOTH, 8'h30, 8'hC3, 8'h00};
        tbl[7]  = '{OP_RD,   8'h30, 8'h00, 8'hC3};
        tbl[8]  = '{OP_WR,   8'h20, 8'hA5, 8'h00};
        tbl[9]  = '{OP_RD,   8'h20, 8'h00, 8'hA5};
        tbl[10] = '{OP_WR,   8'hFF, 8'h3C, 8'h00};
        tbl[11] = '{OP_RD,   8'hFF, 8'h00, 8'h3C};

        for (int i = 0; i < 256; i++) v0[i] = 1'b0;
        for (int i = 0; i < 16; i++)  v1[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({rd_ready, wr_done, data_oe, wp_err}), 32'd0);
        chk("reset_dout", 32'(data_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table on the default instance
        sel = 1'b0;
        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].op, tbl[i].addr, tbl[i].data, rd);
            if (tbl[i].op == OP_RD) chk("table_rd", 32'(rd), 32'(tbl[i].exp));
        end

        // Reset in the middle of RD_WAIT
        address = 8'h20; rd_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rdwait_out", 32'({rd_ready, wr_done, data_oe, wp_err}), 32'd0);
        rd_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Reset while the read is acknowledged clears the bus immediately
        address = 8'h20; rd_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_ack", 32'({rd_ready, data_oe}), 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_rdack_out", 32'({rd_ready, data_oe}), 32'd0);
        chk("rst_rdack_dout", 32'(data_out), 32'd0);
        rd_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Reset during WR_WAIT must not commit the write
        address = 8'h20; data_in = 8'h99; wr_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        wr_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        txn(OP_RD, 8'h20, 8'h00, rd);
        chk("rst_no_partial_wr", 32'(rd), 32'h A5);

        // Address aliasing on the 4-bit index, zero-wait instance
        sel = 1'b1;
        @(negedge clk);
        txn(OP_WR, 8'h13, 8'h77, rd);
        txn(OP_RD, 8'h03, 8'h00, rd);
        chk("wrap_rd", 32'(rd), 32'h77);
        sel = 1'b0;
        @(negedge clk);

`ifdef MEMCARD_WPROT_EN
        txn(OP_RD, 8'h05, 8'h00, snap);
        txn(OP_WR, 8'h05, 8'hFF, rd);
        txn(OP_RD, 8'h05, 8'h00, rd);
        chk("wprot_unchanged", 32'(rd), 32'(snap));
        txn(OP_WR, 8'h10, 8'h42, rd);
        txn(OP_RD, 8'h10, 8'h00, rd);
        chk("wprot_boundary", 32'(rd), 32'h42);
`else
        snap = 8'h00;
        txn(OP_WR, 8'h05, 8'hFF, rd);
        txn(OP_RD, 8'h05, 8'h00, rd);
        chk("low_addr_writable", 32'(rd), 32'(8'hFF ^ snap));
`endif

        // Randomized traffic against the reference images
        for (int i = 0; i < 200; i++) begin
            if ((i % 10) == 0) begin
                sel = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_WR;
                4, 5, 6, 7: op = OP_RD;
                8:          op = OP_BOTH;
                default:    op = ($urandom_range(0, 1) != 0) ? OP_RDAB : OP_WRAB;
            endcase
            a = sel ? 8'($urandom) : 8'($urandom_range(0, 47));
            txn(op, a, 8'($urandom), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
